// File: rtl/axis_slave_if_pkg.sv
// Shared constants for the AXIS receive path: stream-side sizing and RX FSM states,
// plus the inputs-memory geometry used by the DNN/FFT inputs memory.
package axi_stream_pckg;

   localparam int unsigned S_TDATA_WDT     = 32;
   localparam int unsigned S_FIFO_DEPTH    = 8;
   localparam int unsigned S_FIFO_ADDR_WDT = $clog2(S_FIFO_DEPTH);

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_RECV  = 2'd1,
      RX_FLUSH = 2'd2,
      RX_DONE  = 2'd3
   } rx_state_t;

endpackage

package dnn_pckg;

   localparam int unsigned VLW_WDT            = 128;
   localparam int unsigned INPUT_MEM_ADDR_WDT = 10;
   localparam int unsigned INPUT_MEM_OFFSET   = 0;
   localparam int unsigned FRAME_WORDS        = 256;

endpackage

// File: rtl/axis_slave_if_fifo.sv
// Synchronous beat FIFO with full/empty flags; pointers carry one extra wrap bit.
module axis_rx_fifo
   import axi_stream_pckg::*;
#(
   parameter int unsigned DATA_WDT = S_TDATA_WDT + 1,
   parameter int unsigned DEPTH    = S_FIFO_DEPTH,
   parameter int unsigned ADDR_WDT = S_FIFO_ADDR_WDT
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wr_en,
   input  logic [DATA_WDT-1:0] wr_data,
   input  logic                rd_en,
   output logic [DATA_WDT-1:0] rd_data,
   output logic                full,
   output logic                empty
);

   logic [DATA_WDT-1:0] mem_q [DEPTH];
   logic [ADDR_WDT:0]   wr_ptr_q;
   logic [ADDR_WDT:0]   rd_ptr_q;
   logic                do_wr;
   logic                do_rd;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[ADDR_WDT] != rd_ptr_q[ADDR_WDT]) &&
                    (wr_ptr_q[ADDR_WDT-1:0] == rd_ptr_q[ADDR_WDT-1:0]);
   assign do_rd   = rd_en && !empty;
   // A write while full is still fine when the same cycle frees a slot.
   assign do_wr   = wr_en && (!full || do_rd);
   assign rd_data = mem_q[rd_ptr_q[ADDR_WDT-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q[ADDR_WDT-1:0]] <= wr_data;
   end

endmodule

// File: rtl/axis_slave_if.sv
// AXI-Stream slave: buffers beats, packs them MSB-first into memory words and writes them
// sequentially to the inputs memory. TLAST checking is compiled in with AXIS_RX_LAST_CHECK_EN.
module axis_slave_if
   import axi_stream_pckg::*;
#(
   parameter int unsigned S_TDATA_WDT        = axi_stream_pckg::S_TDATA_WDT,
   parameter int unsigned VLW_WDT            = dnn_pckg::VLW_WDT,
   parameter int unsigned INPUT_MEM_ADDR_WDT = dnn_pckg::INPUT_MEM_ADDR_WDT,
   parameter int unsigned INPUT_MEM_OFFSET   = dnn_pckg::INPUT_MEM_OFFSET,
   parameter int unsigned FRAME_WORDS        = dnn_pckg::FRAME_WORDS,
   parameter int unsigned S_FIFO_DEPTH       = axi_stream_pckg::S_FIFO_DEPTH
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [S_TDATA_WDT-1:0]        S_AXIS_TDATA,
   input  logic                          S_AXIS_TLAST,
   input  logic                          S_AXIS_TVALID,
   output logic                          S_AXIS_TREADY,
   output logic [INPUT_MEM_ADDR_WDT-1:0] inputs_ext_mem_addr,
   output logic [VLW_WDT-1:0]            inputs_ext_mem_data,
   output logic                          inputs_ext_mem_wr_en,
   input  logic                          inputs_ext_mem_wr_rdy,
   input  logic                          inputs_rx_start,
   output logic                          inputs_rx_busy,
   output logic                          inputs_rx_done,
   output logic                          inputs_rx_err
);

   localparam int unsigned BPW          = VLW_WDT / S_TDATA_WDT;
   localparam int unsigned FRAME_BEATS  = FRAME_WORDS * BPW;
   localparam int unsigned PACK_CNT_WDT = (BPW > 1) ? $clog2(BPW) : 1;
   localparam int unsigned BEAT_CNT_WDT = $clog2(FRAME_BEATS + 1);
   localparam int unsigned FIFO_AW      = $clog2(S_FIFO_DEPTH);

   rx_state_t                     state_q;
   logic                          busy_q;
   logic                          done_q;
   logic [BEAT_CNT_WDT-1:0]       beat_cnt_q;

   logic                          fifo_full;
   logic                          fifo_empty;
   logic                          fifo_rd;
   logic [S_TDATA_WDT:0]          fifo_wdata;
   logic [S_TDATA_WDT:0]          fifo_rdata;

   logic                          beat_acc;
   logic                          count_end;
   logic                          frame_end;

   logic [VLW_WDT-1:0]            pack_q;
   logic [VLW_WDT-1:0]            pack_d;
   logic [PACK_CNT_WDT-1:0]       pack_cnt_q;
   logic                          pack_full_q;
   logic                          pack_move;
   logic                          beat_last;
   logic [VLW_WDT-1:0]            out_q;
   logic                          wr_en_q;
   logic                          wr_acc;
   logic [INPUT_MEM_ADDR_WDT-1:0] addr_q;

   assign S_AXIS_TREADY = (state_q == RX_RECV) && !fifo_full;
   assign beat_acc      = S_AXIS_TVALID && S_AXIS_TREADY;
   assign count_end     = (beat_cnt_q == BEAT_CNT_WDT'(FRAME_BEATS - 1));

`ifdef AXIS_RX_LAST_CHECK_EN
   logic err_q;
   assign frame_end     = count_end || S_AXIS_TLAST;
   assign inputs_rx_err = err_q;
`else
   logic unused_tlast;
   assign unused_tlast  = S_AXIS_TLAST;
   assign frame_end     = count_end;
   assign inputs_rx_err = 1'b0;
`endif

   // The stored end flag lets the packer close a short final word without knowing the count.
   assign fifo_wdata = {frame_end, S_AXIS_TDATA};

   axis_rx_fifo #(
      .DATA_WDT (S_TDATA_WDT + 1),
      .DEPTH    (S_FIFO_DEPTH),
      .ADDR_WDT (FIFO_AW)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (beat_acc),
      .wr_data (fifo_wdata),
      .rd_en   (fifo_rd),
      .rd_data (fifo_rdata),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign wr_acc    = wr_en_q && inputs_ext_mem_wr_rdy;
   assign pack_move = pack_full_q && (!wr_en_q || inputs_ext_mem_wr_rdy);
   assign fifo_rd   = !fifo_empty && (!pack_full_q || pack_move);
   assign beat_last = fifo_rdata[S_TDATA_WDT];

   // A new word starts from zero so an early end leaves its LSBs padded.
   always_comb begin
      pack_d = (pack_cnt_q == '0) ? '0 : pack_q;
      for (int i = 0; i < BPW; i++) begin
         if (pack_cnt_q == PACK_CNT_WDT'(i)) begin
            pack_d[VLW_WDT-1-i*S_TDATA_WDT -: S_TDATA_WDT] = fifo_rdata[S_TDATA_WDT-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pack_q      <= '0;
         pack_cnt_q  <= '0;
         pack_full_q <= 1'b0;
         out_q       <= '0;
         wr_en_q     <= 1'b0;
      end else begin
         if (pack_move) begin
            out_q       <= pack_q;
            wr_en_q     <= 1'b1;
            pack_full_q <= 1'b0;
         end else if (wr_acc) begin
            wr_en_q     <= 1'b0;
         end
         if (fifo_rd) begin
            pack_q <= pack_d;
            if (beat_last || (pack_cnt_q == PACK_CNT_WDT'(BPW - 1))) begin
               pack_cnt_q  <= '0;
               pack_full_q <= 1'b1;
            end else begin
               pack_cnt_q  <= pack_cnt_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q <= INPUT_MEM_ADDR_WDT'(INPUT_MEM_OFFSET);
      end else if (state_q == RX_IDLE) begin
         addr_q <= INPUT_MEM_ADDR_WDT'(INPUT_MEM_OFFSET);
      end else if (wr_acc) begin
         addr_q <= addr_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RX_IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         beat_cnt_q <= '0;
`ifdef AXIS_RX_LAST_CHECK_EN
         err_q      <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            RX_IDLE: begin
               done_q <= 1'b0;
               if (inputs_rx_start) begin
                  state_q    <= RX_RECV;
                  busy_q     <= 1'b1;
                  beat_cnt_q <= '0;
`ifdef AXIS_RX_LAST_CHECK_EN
                  err_q      <= 1'b0;
`endif
               end
            end
            RX_RECV: begin
               if (beat_acc) begin
                  beat_cnt_q <= beat_cnt_q + 1'b1;
`ifdef AXIS_RX_LAST_CHECK_EN
                  // Covers both early TLAST and TLAST missing on the final counted beat.
                  if (S_AXIS_TLAST != count_end) err_q <= 1'b1;
`endif
                  if (frame_end) state_q <= RX_FLUSH;
               end
            end
            RX_FLUSH: begin
               if (fifo_empty && !pack_full_q && (!wr_en_q || inputs_ext_mem_wr_rdy)) begin
                  state_q <= RX_DONE;
                  done_q  <= 1'b1;
               end
            end
            RX_DONE: begin
               state_q <= RX_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= RX_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign inputs_ext_mem_addr  = addr_q;
   assign inputs_ext_mem_data  = out_q;
   assign inputs_ext_mem_wr_en = wr_en_q;
   assign inputs_rx_busy       = busy_q;
   assign inputs_rx_done       = done_q;

endmodule

// File: tb/tb_axis_slave_if.sv
// Directed bench for axis_slave_if with BPW=4 and two-word frames; expectations follow
// AXIS_RX_LAST_CHECK_EN when it is defined.
module tb_axis_slave_if;

   localparam logic [127:0] W0  = {32'd1, 32'd2, 32'd3, 32'd4};
   localparam logic [127:0] W1  = {32'd5, 32'd6, 32'd7, 32'd8};
   localparam logic [127:0] W1S = {32'd5, 32'd6, 64'd0};

   logic         clk;
   logic         rst_n;
   logic [31:0]  S_AXIS_TDATA;
   logic         S_AXIS_TLAST;
   logic         S_AXIS_TVALID;
   logic         S_AXIS_TREADY;
   logic [9:0]   inputs_ext_mem_addr;
   logic [127:0] inputs_ext_mem_data;
   logic         inputs_ext_mem_wr_en;
   logic         inputs_ext_mem_wr_rdy;
   logic         inputs_rx_start;
   logic         inputs_rx_busy;
   logic         inputs_rx_done;
   logic         inputs_rx_err;

   axis_slave_if #(
      .FRAME_WORDS (2)
   ) dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .S_AXIS_TDATA          (S_AXIS_TDATA),
      .S_AXIS_TLAST          (S_AXIS_TLAST),
      .S_AXIS_TVALID         (S_AXIS_TVALID),
      .S_AXIS_TREADY         (S_AXIS_TREADY),
      .inputs_ext_mem_addr   (inputs_ext_mem_addr),
      .inputs_ext_mem_data   (inputs_ext_mem_data),
      .inputs_ext_mem_wr_en  (inputs_ext_mem_wr_en),
      .inputs_ext_mem_wr_rdy (inputs_ext_mem_wr_rdy),
      .inputs_rx_start       (inputs_rx_start),
      .inputs_rx_busy        (inputs_rx_busy),
      .inputs_rx_done        (inputs_rx_done),
      .inputs_rx_err         (inputs_rx_err)
   );

   typedef struct {
      string        name;
      int           nbeats;
      int           tlast_pos;
      bit           toggle;
      int           rdy_low;
      int           exp_beats;
      logic [127:0] exp_w0;
      logic [127:0] exp_w1;
      int           exp_writes;
      bit           exp_err;
   } vec_t;

   vec_t         vecs [5];
   int           checks;
   int           failures;
   int           cyc;
   logic [127:0] mem_model [16];
   int           wr_count;
   int           done_cnt;
   bit           first_wr_seen;
   int           first_wr_cyc;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Memory and done monitor, sampled mid low phase.
   always begin
      @(negedge clk);
      #2;
      if (inputs_ext_mem_wr_en && inputs_ext_mem_wr_rdy) begin
         mem_model[inputs_ext_mem_addr[3:0]] = inputs_ext_mem_data;
         wr_count = wr_count + 1;
      end
      if (inputs_rx_done) done_cnt = done_cnt + 1;
      if (inputs_ext_mem_wr_en && !first_wr_seen) begin
         first_wr_seen = 1'b1;
         first_wr_cyc  = cyc;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Present one beat from a negedge; got=1 once it has been accepted.
   task automatic send_beat(input int data, input bit last, output bit got);
      bit rdy_seen;
      S_AXIS_TDATA  = data;
      S_AXIS_TLAST  = last;
      S_AXIS_TVALID = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 40; c++) begin
         #1;
         rdy_seen = S_AXIS_TREADY;
         @(negedge clk);
         if (rdy_seen) begin
            got = 1'b1;
            break;
         end
      end
      S_AXIS_TVALID = 1'b0;
      S_AXIS_TLAST  = 1'b0;
   endtask

   task automatic run_frame(input vec_t v);
      int   acc;
      int   beat4_cyc;
      logic tready_after;
      bit   got;
      acc          = 0;
      beat4_cyc    = -100;
      tready_after = 1'b1;
      for (int i = 0; i < 16; i++) mem_model[i] = '0;
      wr_count      = 0;
      done_cnt      = 0;
      first_wr_seen = 1'b0;
      first_wr_cyc  = 0;
      inputs_ext_mem_wr_rdy = (v.rdy_low == 0);
      @(negedge clk);
      inputs_rx_start = 1'b1;
      @(negedge clk);
      inputs_rx_start = 1'b0;
      fork
         begin
            for (int b = 1; b <= v.nbeats; b++) begin
               if (v.toggle && b > 1) @(negedge clk);
               send_beat(b, (b == v.tlast_pos), got);
               if (!got) break;
               acc = acc + 1;
               if (acc == 4) beat4_cyc = cyc;
               if (acc == v.exp_beats) tready_after = S_AXIS_TREADY;
            end
         end
         begin
            if (v.rdy_low > 0) begin
               for (int c = 0; c < 200; c++) begin
                  @(negedge clk);
                  #1;
                  if (inputs_ext_mem_wr_en) break;
               end
               repeat (v.rdy_low) @(negedge clk);
               inputs_ext_mem_wr_rdy = 1'b1;
            end
         end
      join
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (!inputs_rx_busy) break;
      end
      repeat (2) @(negedge clk);
      check({v.name, "_beats"}, acc, v.exp_beats);
      check({v.name, "_tready_flush"}, tready_after, 1'b0);
      check({v.name, "_latency"}, first_wr_cyc - beat4_cyc, 2);
      check({v.name, "_writes"}, wr_count, v.exp_writes);
      check({v.name, "_word0"}, mem_model[0], v.exp_w0);
      check({v.name, "_word1"}, mem_model[1], v.exp_w1);
      check({v.name, "_done_pulses"}, done_cnt, 1);
      check({v.name, "_err"}, inputs_rx_err, v.exp_err);
      check({v.name, "_addr_idle"}, inputs_ext_mem_addr, 10'd0);
      check({v.name, "_busy_end"}, inputs_rx_busy, 1'b0);
   endtask

   initial begin
      bit got;
      checks   = 0;
      failures = 0;
      cyc      = 0;
      wr_count = 0;
      done_cnt = 0;
      first_wr_seen = 1'b0;
      first_wr_cyc  = 0;

      vecs[0] = '{"normal", 8, 8, 1'b0, 0, 8, W0, W1, 2, 1'b0};
      vecs[1] = '{"toggle", 8, 8, 1'b1, 0, 8, W0, W1, 2, 1'b0};
`ifdef AXIS_RX_LAST_CHECK_EN
      vecs[2] = '{"tlast_early", 8, 6, 1'b0, 0, 6, W0, W1S, 2, 1'b1};
      vecs[4] = '{"no_tlast", 9, 0, 1'b0, 0, 8, W0, W1, 2, 1'b1};
`else
      vecs[2] = '{"tlast_early", 8, 6, 1'b0, 0, 8, W0, W1, 2, 1'b0};
      vecs[4] = '{"no_tlast", 9, 0, 1'b0, 0, 8, W0, W1, 2, 1'b0};
`endif
      vecs[3] = '{"rdy_stall", 8, 8, 1'b0, 20, 8, W0, W1, 2, 1'b0};

      rst_n                 = 1'b0;
      S_AXIS_TDATA          = '0;
      S_AXIS_TLAST          = 1'b0;
      S_AXIS_TVALID         = 1'b0;
      inputs_ext_mem_wr_rdy = 1'b1;
      inputs_rx_start       = 1'b0;
      #3;
      check("rst_tready", S_AXIS_TREADY, 1'b0);
      check("rst_wr_en", inputs_ext_mem_wr_en, 1'b0);
      check("rst_addr", inputs_ext_mem_addr, 10'd0);
      check("rst_data", inputs_ext_mem_data, 128'd0);
      check("rst_busy", inputs_rx_busy, 1'b0);
      check("rst_done", inputs_rx_done, 1'b0);
      check("rst_err", inputs_rx_err, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 5; i++) run_frame(vecs[i]);

      // Abort a frame after three beats with an asynchronous reset.
      done_cnt = 0;
      inputs_ext_mem_wr_rdy = 1'b1;
      inputs_rx_start = 1'b1;
      @(negedge clk);
      inputs_rx_start = 1'b0;
      for (int b = 1; b <= 3; b++) send_beat(b, 1'b0, got);
      check("abort_busy_before", inputs_rx_busy, 1'b1);
      #3;
      rst_n = 1'b0;
      #1;
      check("abort_tready", S_AXIS_TREADY, 1'b0);
      check("abort_busy", inputs_rx_busy, 1'b0);
      check("abort_wr_en", inputs_ext_mem_wr_en, 1'b0);
      check("abort_addr", inputs_ext_mem_addr, 10'd0);
      check("abort_done", inputs_rx_done, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("abort_no_done", done_cnt, 0);
      vecs[0].name = "after_abort";
      run_frame(vecs[0]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
